// File: rtl/dma_controller_arb.sv
// DMA channel request arbiter: priority select with round-robin tie break,
// valid/ready offer to the engine, one-cycle acknowledge back to the peripheral.
module dma_controller_arb #(
  parameter int CHANNELS_AMOUNT = 4,
  parameter int PRIO_W          = 2,
  localparam int CH_W = (CHANNELS_AMOUNT > 1) ? $clog2(CHANNELS_AMOUNT) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [CHANNELS_AMOUNT-1:0]        channel_req_i,
  input  logic [CHANNELS_AMOUNT-1:0]        channel_en_i,
  input  logic [CHANNELS_AMOUNT*PRIO_W-1:0] channel_prio_i,
  input  logic                              dma_ready_i,
  input  logic                              dma_done_i,
  output logic                              arb_req_valid_o,
  output logic [CH_W-1:0]                   arb_req_channel_o,
  output logic [CHANNELS_AMOUNT-1:0]        channel_ack_o,
  output logic                              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    BUSY,
    ACK
  } state_t;

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [CH_W-1:0]            rr_q, rr_d;
  logic [CHANNELS_AMOUNT-1:0] hold_q, hold_d;

  logic [CHANNELS_AMOUNT-1:0] elig;
  logic [CHANNELS_AMOUNT-1:0] ch_oh;
  logic [PRIO_W-1:0]          prio [CHANNELS_AMOUNT];
  logic [PRIO_W-1:0]          max_prio;
  logic                       any_elig;
  logic                       found;
  logic [CH_W-1:0]            sel;

  assign elig  = channel_req_i & channel_en_i & ~hold_q;
  assign ch_oh = CHANNELS_AMOUNT'(1) << ch_q;

  // Highest level first, then first match scanning upward from rr_q.
  always_comb begin
    max_prio = '0;
    any_elig = 1'b0;
    found    = 1'b0;
    sel      = '0;
    for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
      prio[i] = channel_prio_i[i*PRIO_W +: PRIO_W];
    end
    for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
      if (elig[i] && (!any_elig || prio[i] > max_prio)) begin
        max_prio = prio[i];
        any_elig = 1'b1;
      end
    end
    for (int i = 0; i < CHANNELS_AMOUNT; i++) begin
      int k;
      k = int'(rr_q) + i;
      if (k >= CHANNELS_AMOUNT) k = k - CHANNELS_AMOUNT;
      if (!found && elig[k] && prio[k] == max_prio) begin
        found = 1'b1;
        sel   = CH_W'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    hold_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (any_elig) begin
          ch_d    = sel;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (dma_ready_i) begin
          state_d = BUSY;
          rr_d = (ch_q == CH_W'(CHANNELS_AMOUNT-1)) ? '0 : ch_q + 1'b1;
        end else if (!channel_en_i[ch_q] || !channel_req_i[ch_q]) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (dma_done_i) state_d = ACK;
      end
      ACK: begin
        hold_d  = ch_oh;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  assign arb_req_valid_o   = (state_q == OFFER);
  assign arb_req_channel_o = ch_q;
  assign channel_ack_o     = (state_q == ACK) ? ch_oh : '0;
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_dma_controller_arb.sv
// Directed bench for dma_controller_arb with hand-computed expectations.
module tb_dma_controller_arb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] en = '0;
  logic [7:0] prio = '0;
  logic       ready = 1'b0;
  logic       done = 1'b0;
  logic       valid;
  logic [1:0] ch;
  logic [3:0] ack;
  logic       busy;

  int vec_cnt = 0;
  int miss_cnt = 0;

  dma_controller_arb #(
    .CHANNELS_AMOUNT(4),
    .PRIO_W(2)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .channel_req_i    (req),
    .channel_en_i     (en),
    .channel_prio_i   (prio),
    .dma_ready_i      (ready),
    .dma_done_i       (done),
    .arb_req_valid_o  (valid),
    .arb_req_channel_o(ch),
    .channel_ack_o    (ack),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_offer();
    int n = 0;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
    chk("offer_seen", 32'(valid), 1);
  endtask

  // Accept the current offer, pulse done after `gap` busy cycles, land in ACK.
  task automatic serve(input int gap);
    ready = 1'b1;
    tick();
    for (int i = 0; i < gap - 1; i++) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    int exp_rr[6] = '{0, 1, 3, 0, 1, 3};
    int last = -1;

    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_ch", 32'(ch), 0);
    tick();
    rst_n = 1'b1;

    // single request on ch2
    en = 4'b1111;
    req = 4'b0100;
    ready = 1'b1;
    tick();
    chk("t1_valid", 32'(valid), 1);
    chk("t1_ch", 32'(ch), 2);
    tick();
    chk("t1_busy_state", 32'(busy), 1);
    chk("t1_busy_valid", 32'(valid), 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    req = 4'b0000;
    chk("t1_ack", 32'(ack), 4);
    tick();
    chk("t1_ack_gone", 32'(ack), 0);
    chk("t1_idle", 32'(busy), 0);

    // round-robin tie at prio 1
    do_reset();
    prio = 8'b01_01_01_01;
    req = 4'b1011;
    for (int g = 0; g < 6; g++) begin
      wait_offer();
      chk($sformatf("rr_%0d", g), 32'(ch), 32'(exp_rr[g]));
      chk($sformatf("rr_norepeat_%0d", g), 32'(int'(ch) != last), 1);
      last = int'(ch);
      serve(3);
    end
    req = 4'b0000;
    tick();

    // priority override
    do_reset();
    prio = 8'b11_00_00_00;
    req = 4'b1001;
    wait_offer();
    chk("prio_first", 32'(ch), 3);
    serve(1);
    chk("prio_ack3", 32'(ack), 8);
    wait_offer();
    chk("prio_second", 32'(ch), 0);
    req = 4'b0000;
    serve(1);
    tick();

    // ready stall then disable
    do_reset();
    prio = 8'b01_01_01_01;
    ready = 1'b0;
    req = 4'b0010;
    wait_offer();
    chk("stall_ch", 32'(ch), 1);
    tick();
    chk("stall_hold_v", 32'(valid), 1);
    tick();
    chk("stall_hold_ch", 32'(ch), 1);
    en = 4'b1101;
    tick();
    chk("wd_valid", 32'(valid), 0);
    chk("wd_busy", 32'(busy), 0);
    chk("wd_ack", 32'(ack), 0);
    tick();
    chk("wd_no_ack", 32'(ack), 0);
    en = 4'b1111;
    req = 4'b1011;
    wait_offer();
    chk("wd_rr_kept", 32'(ch), 0);
    // disable and ready in the same cycle: accept wins
    ready = 1'b1;
    en = 4'b1110;
    tick();
    chk("race_busy", 32'(busy), 1);
    chk("race_valid", 32'(valid), 0);
    en = 4'b1111;
    req = 4'b0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("race_ack", 32'(ack), 1);
    tick();

    // holdoff on the just-acked channel
    do_reset();
    req = 4'b0100;
    ready = 1'b1;
    wait_offer();
    serve(1);
    chk("ho_ack", 32'(ack), 4);
    tick();
    chk("ho_idle1", 32'(valid), 0);
    chk("ho_idle1_ack", 32'(ack), 0);
    tick();
    chk("ho_idle2", 32'(valid), 0);
    tick();
    chk("ho_reoffer", 32'(valid), 1);
    chk("ho_reoffer_ch", 32'(ch), 2);
    req = 4'b0000;
    serve(1);
    tick();

    // async reset mid-BUSY
    do_reset();
    req = 4'b0010;
    wait_offer();
    tick();
    chk("ar_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_busy0", 32'(busy), 0);
    chk("ar_valid0", 32'(valid), 0);
    chk("ar_ch0", 32'(ch), 0);
    chk("ar_ack0", 32'(ack), 0);
    req = 4'b1011;
    tick();
    chk("ar_held_ack", 32'(ack), 0);
    rst_n = 1'b1;
    wait_offer();
    chk("ar_rr_clean", 32'(ch), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/dma_controller_arb.md
Name: dma_controller_arb

Overview:
Channel request arbiter feeding the DMA controller engine. Collects level-sensitive DMA requests from up to CHANNELS_AMOUNT peripheral channels. Selects one channel by programmed priority, breaking ties round-robin, and offers it to the engine with a valid/ready handshake. It tracks the channel while the engine services it, then returns a one-cycle acknowledge to the requesting peripheral.

Parameters:
CHANNELS_AMOUNT, 4, number of DMA channels (1..16)
PRIO_W, 2, width of per-channel priority level; higher value wins
CH_W, $clog2(CHANNELS_AMOUNT) (min 1), width of channel index (derived localparam)

Ports:
clk_i  input  1  single clock, all logic rising-edge
rst_n_i  input  1  asynchronous active-low reset
channel_req_i  input  CHANNELS_AMOUNT  level request per channel from peripheral
channel_en_i  input  CHANNELS_AMOUNT  channel enable from config registers
channel_prio_i  input  CHANNELS_AMOUNT*PRIO_W  packed priority level per channel
dma_ready_i  input  1  engine idle and accepting a new channel
dma_done_i  input  1  engine finished servicing the accepted channel (1-cycle pulse)
arb_req_valid_o  output  1  a selected channel is offered to the engine
arb_req_channel_o  output  CH_W  offered/active channel index
channel_ack_o  output  CHANNELS_AMOUNT  one-hot 1-cycle acknowledge to peripheral
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clock, asynchronous active-low (rst_n_i low clears state immediately, release synchronous to clk_i). Values while reset is asserted: state=IDLE, arb_req_valid_o=0, arb_req_channel_o=0, channel_ack_o=0, busy_o=0, rr_ptr=0, holdoff mask=0.
- Eligible[n] = channel_req_i[n] & channel_en_i[n] & ~holdoff[n].
- Selection (combinational, used only in IDLE):
  - Find the maximum priority among eligible channels.
  - Among channels at that level, pick the first found scanning upward from rr_ptr, wrapping modulo CHANNELS_AMOUNT.
- States:
  - IDLE: if any eligible channel, register the selected index into arb_req_channel_o and go to OFFER. Latency is 1 cycle: a request sampled at edge t gives arb_req_valid_o=1 after edge t.
  - OFFER: arb_req_valid_o=1; arb_req_channel_o is held stable.
    - If dma_ready_i=1: accept; rr_ptr <= channel+1 (wraps to 0 after CHANNELS_AMOUNT-1); go to BUSY.
    - Else, if channel_en_i[channel]=0 or channel_req_i[channel]=0: withdraw, arb_req_valid_o=0 next cycle, go to IDLE, rr_ptr unchanged.
    - Enable and ready both changing in the same cycle: the accept wins.
    - Priority changes during OFFER do not re-arbitrate.
  - BUSY: arb_req_valid_o=0, arb_req_channel_o held. On dma_done_i, go to ACK. Channel disable or request drop in BUSY is ignored; the engine owns abort. dma_done_i outside BUSY is ignored.
  - ACK: channel_ack_o[channel]=1 for exactly one cycle; set holdoff[channel]; go to IDLE.
- Holdoff: the holdoff bit is cleared one cycle after it is set. The acked channel is therefore ineligible during the first IDLE cycle, giving the peripheral time to drop its level request. Other channels may win in that cycle.
- Priority is unsigned. With equal levels, channels are served in round-robin order.
- CHANNELS_AMOUNT=1: rr_ptr is constant 0 and the arbiter degenerates to a handshake FSM.
- Unused channel_ack_o bits are always 0; at most one bit is high in any cycle.
- Reset asserted mid-OFFER or mid-BUSY: outputs clear immediately. No ack is issued for the interrupted channel.

Test Plan:
- Single request: CH=4; ch2 req+en, prio 0, dma_ready_i=1 -> arb_req_valid_o=1 with channel=2 one cycle later; accept; dma_done_i pulse -> channel_ack_o=4'b0100 for 1 cycle; busy_o low the following cycle.
- Round-robin tie: ch0, ch1 and ch3 all held high at prio 1; engine always ready; done 3 cycles after each accept -> grant order 0,1,3,0,1,3, with no channel granted twice in a row.
- Priority override: ch0 prio 0 and ch3 prio 3 requesting, rr_ptr=0 -> ch3 granted first, then ch0 on the next arbitration.
- Ready stall then disable: ch1 offered, dma_ready_i=0 for 5 cycles; channel_en_i[1] dropped in cycle 3 -> arb_req_valid_o falls the next cycle, state IDLE, no ack, rr_ptr unchanged.
- Holdoff: ch2 keeps req high after its ack, ch2 is the only requester -> no offer in the first IDLE cycle; ch2 is re-offered on the cycle after.
- Async reset: rst_n_i pulsed low mid-BUSY between clock edges -> all outputs 0 immediately; after release with ch0 requesting -> ch0 offered from a clean IDLE with rr_ptr=0.
